snake_dir_ctrl: RTL

- Upstream stage of the snake game engine. It conditions the four raw direction buttons and produces the one-hot direction levels (up, down, left, right) that the game engine consumes.
- It also generates the game-step pulse that paces snake movement.
- Reversal requests (e.g. left while moving right) are filtered here, so the engine only ever sees legal directions.

---
 rtl/snake_dir_ctrl_if.sv | 33 +++
 rtl/snake_dir_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl_if.sv
// Button-to-direction bundle between the board inputs and the direction controller.
// Latency: n/a (wires only).
// Backpressure: none; buttons are levels, outputs are levels/pulses.
//
// Signals:
//   btn_up/down/left/right : raw asynchronous buttons, active-high (toward controller)
//   up/down/left/right     : one-hot current direction (from controller)
//   step                   : one-cycle game-step pulse (from controller)
//   reject                 : one-cycle pulse, reversal request discarded at a step
interface snake_dir_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic up;
    logic down;
    logic left;
    logic right;
    logic step;
    logic reject;

    // Board / bench side: drives buttons, observes direction and pulses.
    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        input  up, down, left, right, step, reject
    );

    // Controller side.
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        output up, down, left, right, step, reject
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Conditions raw direction buttons into a legal one-hot snake direction and paces game steps.
// Latency: raw press to clean level 2+DEBOUNCE_CYCLES cycles; direction changes only on the step edge.
// Backpressure: none; presses between steps are held in a one-deep pending slot (last press wins).
//
// Ports:
//   slw_clk : sole clock, rising edge
//   reset   : synchronous, active-low
//   bus     : snake_dir_ctrl_if.slave (buttons in; up/down/left/right, step, reject out)
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_DIV        = 8
) (
    input  logic              slw_clk,
    input  logic              reset,
    snake_dir_ctrl_if.slave   bus
);

    // Direction codes chosen so that the opposite direction is code ^ 1.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);

    // Button vector indexed by direction code.
    logic [3:0] w_btn_raw;
    assign w_btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_clean;
    logic [3:0] r_clean_d;
    logic [7:0] r_db_cnt [4];

    // Synchronizer and per-button debounce.
    always_ff @(posedge slw_clk) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_clean   <= '0;
            r_clean_d <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_btn_raw;
            r_sync2   <= r_sync1;
            r_clean_d <= r_clean;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_clean[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    // Mismatch has now persisted DEBOUNCE_CYCLES edges.
                    r_clean[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Press events (rising clean level only) with fixed priority up > down > left > right.
    logic [3:0] w_press;
    logic       w_press_vld;
    logic [1:0] w_press_code;

    assign w_press     = r_clean & ~r_clean_d;
    assign w_press_vld = |w_press;

    always_comb begin
        w_press_code = DIR_RIGHT;
        if (w_press[DIR_UP]) begin
            w_press_code = DIR_UP;
        end else if (w_press[DIR_DOWN]) begin
            w_press_code = DIR_DOWN;
        end else if (w_press[DIR_LEFT]) begin
            w_press_code = DIR_LEFT;
        end
    end

    logic [15:0] r_step_cnt;
    logic        r_step;
    logic        r_reject;
    logic [1:0]  r_dir;
    logic        r_pend_vld;
    logic [1:0]  r_pend_code;

    logic        w_step_edge;
    logic        w_cand_vld;
    logic [1:0]  w_cand_code;
    logic        w_cand_rev;

    assign w_step_edge = (r_step_cnt == STEP_LAST);
    // A press landing exactly on the step edge bypasses the pending slot.
    assign w_cand_vld  = w_press_vld | r_pend_vld;
    assign w_cand_code = w_press_vld ? w_press_code : r_pend_code;
    assign w_cand_rev  = (w_cand_code == (r_dir ^ 2'b01));

    always_ff @(posedge slw_clk) begin
        if (!reset) begin
            r_step_cnt  <= '0;
            r_step      <= 1'b0;
            r_reject    <= 1'b0;
            r_dir       <= DIR_RIGHT;
            r_pend_vld  <= 1'b0;
            r_pend_code <= '0;
        end else begin
            r_step   <= w_step_edge;
            r_reject <= 1'b0;
            if (w_step_edge) begin
                r_step_cnt <= '0;
                r_pend_vld <= 1'b0;
                if (w_cand_vld) begin
                    if (w_cand_rev) begin
                        r_reject <= 1'b1;
                    end else begin
                        // Same-direction candidate rewrites the same value: a hold.
                        r_dir <= w_cand_code;
                    end
                end
            end else begin
                r_step_cnt <= r_step_cnt + 16'd1;
                if (w_press_vld) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_code <= w_press_code;
                end
            end
        end
    end

    // Decoded from a 2-bit code, so exactly one output is ever high.
    assign bus.up     = (r_dir == DIR_UP);
    assign bus.down   = (r_dir == DIR_DOWN);
    assign bus.left   = (r_dir == DIR_LEFT);
    assign bus.right  = (r_dir == DIR_RIGHT);
    assign bus.step   = r_step;
    assign bus.reject = r_reject;

endmodule
